// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int ADC_W   = 12;
    localparam int MAX_REQ = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SETTLE,
        CONV,
        DELIVER
    } state_t;

    function automatic logic onehot0(
        input logic [MAX_REQ-1:0] v
    );
        return (v & (v - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/adc_sample_sched_rr_arbiter.sv
// Round-robin pick: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               found
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found &&
                req[IW'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                gnt[IW'((int'(ptr) + i) % NUM_REQ)] = 1'b1;
                idx = IW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// Paces and arbitrates conversions of the shared SWIPT ADC,
// then hands each sample to its requester over valid/ready.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SAMPLE_PERIOD = 200,
    parameter int SETTLE_CYCLES = 4,
    parameter int CONV_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               swiptAlive,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               adc_start,
    input  logic               adc_done,
    input  logic [ADC_W-1:0]   ADC,
    output logic [ADC_W-1:0]   result_data,
    output logic [NUM_REQ-1:0] result_valid,
    input  logic [NUM_REQ-1:0] result_ready,
    output logic               timeout_err,
    output logic               tick_overrun
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = (SAMPLE_PERIOD > 1) ?
                        $clog2(SAMPLE_PERIOD) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ?
                        $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(CONV_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic               pend_q, pend_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SW-1:0]      scnt_q, scnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               drop_q, drop_d;
    logic [ADC_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;
    logic               start_q, start_d;
    logic               terr_q, terr_d;
    logic               ovr_q, ovr_d;

    logic               tick;
    logic               consume;
    logic               drop_now;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_found;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (req),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .found(arb_found)
    );

    always_comb begin
        tick     = (pcnt_q == '0);
        consume  = (state_q == IDLE) && pend_q && (|req);
        pcnt_d   = tick ? PW'(SAMPLE_PERIOD - 1)
                        : pcnt_q - 1'b1;
        // A tick landing on the consuming cycle re-arms pending.
        pend_d   = tick | (pend_q & ~consume);
        ovr_d    = tick & pend_q & ~consume;
        drop_now = drop_q | ~req[gidx_q];

        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        scnt_d   = scnt_q;
        tcnt_d   = tcnt_q;
        drop_d   = drop_q;
        data_d   = data_q;
        valid_d  = valid_q;
        start_d  = 1'b0;
        terr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (consume) state_d = ARB;
            end
            ARB: begin
                if (arb_found) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    scnt_d  = '0;
                    drop_d  = 1'b0;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                drop_d = drop_now;
                if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    start_d = 1'b1;
                    tcnt_d  = TW'(1);
                    state_d = CONV;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            CONV: begin
                if (adc_done) begin
                    if (drop_now) begin
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        state_d = IDLE;
                    end else begin
                        data_d  = ADC;
                        valid_d = grant_q;
                        state_d = DELIVER;
                    end
                end else if (tcnt_q == TW'(CONV_TIMEOUT)) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    drop_d = drop_now;
                end
            end
            DELIVER: begin
                if (|(valid_q & result_ready)) begin
                    valid_d = '0;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            pcnt_q  <= PW'(SAMPLE_PERIOD - 1);
            pend_q  <= 1'b0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (!swiptAlive) begin
            state_q <= IDLE;
            pcnt_q  <= PW'(SAMPLE_PERIOD - 1);
            pend_q  <= 1'b0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            scnt_q  <= scnt_d;
            tcnt_q  <= tcnt_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign grant        = grant_q;
    assign adc_start    = start_q;
    assign result_data  = data_q;
    assign result_valid = valid_q;
    assign timeout_err  = terr_q;
    assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// Directed bench for adc_sample_sched (default parameters).
module tb_adc_sample_sched;
    import adc_sched_pkg::*;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             nrst;
    logic             swiptAlive;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] ADC;
    logic [ADC_W-1:0] result_data;
    logic [N-1:0]     result_valid;
    logic [N-1:0]     result_ready;
    logic             timeout_err;
    logic             tick_overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0;
    int last_start = -1;
    int n_terr = 0;
    int n_ovr = 0;
    int n_oh = 0;
    int o0;

    always #5 clk = ~clk;

    adc_sample_sched #(
        .NUM_REQ(N),
        .SAMPLE_PERIOD(200),
        .SETTLE_CYCLES(4),
        .CONV_TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .swiptAlive  (swiptAlive),
        .req         (req),
        .grant       (grant),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .ADC         (ADC),
        .result_data (result_data),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .timeout_err (timeout_err),
        .tick_overrun(tick_overrun)
    );

    wire [31:0] outs = 32'({grant, adc_start, result_data,
                            result_valid, timeout_err,
                            tick_overrun});

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (adc_start) begin
            n_start++;
            last_start = cyc;
        end
        if (timeout_err) n_terr++;
        if (tick_overrun) n_ovr++;
        if (!onehot0(MAX_REQ'(grant)) ||
            !onehot0(MAX_REQ'(result_valid)))
            n_oh++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic serve(input logic [ADC_W-1:0] d,
                         input logic [N-1:0] g);
        adc_done = 1'b1;
        ADC      = d;
        step();
        adc_done = 1'b0;
        chk("serve_valid", 32'(result_valid), 32'(g));
        chk("serve_data", 32'(result_data), 32'(d));
        result_ready = 2'b11;
        step();
        result_ready = '0;
        chk("serve_clear", 32'(result_valid), 0);
    endtask

    initial begin
        nrst         = 1'b0;
        swiptAlive   = 1'b1;
        req          = '0;
        result_ready = '0;
        adc_done     = 1'b0;
        ADC          = '0;
        repeat (3) step();
        chk("reset_outs", outs, 0);
        nrst = 1'b1;
        cyc  = 0;

        // single requester: tick at 199, start at 206
        req = 2'b01;
        run_to(201);
        chk("grant_pre", 32'(grant), 0);
        run_to(202);
        chk("grant_t3", 32'(grant), 32'h1);
        run_to(205);
        chk("start_early", 32'(adc_start), 0);
        run_to(206);
        chk("start_t7", 32'(adc_start), 1);
        chk("start_cyc", 32'(last_start), 206);
        adc_done = 1'b1;
        ADC      = 12'h7FF;
        step();
        adc_done = 1'b0;
        chk("t2_valid", 32'(result_valid), 32'h1);
        chk("t2_data", 32'(result_data), 32'h7FF);
        step();
        chk("t2_hold", 32'(result_valid), 32'h1);
        result_ready = 2'b01;
        step();
        result_ready = '0;
        chk("t2_vdrop", 32'(result_valid), 0);
        chk("t2_gdrop", 32'(grant), 0);

        // both requesting: grants alternate, 200-cycle spacing
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_to(406 + 200 * i);
            chk("rr_start", 32'(adc_start), 1);
            chk("rr_grant", 32'(grant),
                (i % 2 == 0) ? 32'h2 : 32'h1);
            serve(12'h100 + 12'(i),
                  (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // no done: timeout 64 cycles after start
        run_to(1206);
        chk("to_grant", 32'(grant), 32'h2);
        run_to(1269);
        chk("to_early", 32'(timeout_err), 0);
        run_to(1270);
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_gdrop", 32'(grant), 0);
        step();
        chk("to_once", 32'(timeout_err), 0);
        run_to(1406);
        chk("to_other", 32'(grant), 32'h1);
        serve(12'h222, 2'b01);

        // done on the expiry cycle wins
        run_to(1669);
        chk("edge_grant", 32'(grant), 32'h2);
        adc_done = 1'b1;
        ADC      = 12'h3C3;
        step();
        adc_done = 1'b0;
        chk("edge_valid", 32'(result_valid), 32'h2);
        chk("edge_data", 32'(result_data), 32'h3C3);
        chk("edge_noerr", 32'(timeout_err), 0);
        result_ready = 2'b10;
        step();
        result_ready = '0;
        chk("edge_clear", 32'(result_valid), 0);

        // stray done in IDLE
        run_to(1680);
        adc_done = 1'b1;
        ADC      = 12'hABC;
        step();
        adc_done = 1'b0;
        step();
        chk("stray_data", 32'(result_data), 32'h3C3);
        chk("stray_valid", 32'(result_valid), 0);

        // stalled consumer: overrun on the second pending tick
        run_to(1806);
        chk("ov_grant", 32'(grant), 32'h1);
        adc_done = 1'b1;
        ADC      = 12'h5A5;
        step();
        adc_done = 1'b0;
        chk("ov_valid", 32'(result_valid), 32'h1);
        o0 = n_ovr;
        run_to(2199);
        chk("ov_none", 32'(tick_overrun), 0);
        run_to(2200);
        chk("ov_pulse", 32'(tick_overrun), 1);
        run_to(2250);
        chk("ov_hold", 32'(result_valid), 32'h1);
        chk("ov_data", 32'(result_data), 32'h5A5);
        result_ready = 2'b01;
        step();
        result_ready = '0;
        chk("ov_clear", 32'(result_valid), 0);
        chk("ov_count", 32'(n_ovr - o0), 1);
        run_to(2253);
        chk("pend_grant", 32'(grant), 32'h2);
        run_to(2257);
        chk("pend_start", 32'(last_start), 2257);
        serve(12'h0F0, 2'b10);

        // requester drops during CONV: sample discarded
        run_to(2406);
        chk("drop_grant0", 32'(grant), 32'h1);
        req      = 2'b10;
        adc_done = 1'b1;
        ADC      = 12'h777;
        step();
        adc_done = 1'b0;
        chk("drop_valid", 32'(result_valid), 0);
        chk("drop_grant", 32'(grant), 0);
        chk("drop_data", 32'(result_data), 32'h0F0);

        // async reset mid-CONV
        run_to(2610);
        chk("arst_pre", 32'(grant), 32'h2);
        nrst = 1'b0;
        #1;
        chk("arst_outs", outs, 0);
        step();
        step();
        nrst = 1'b1;
        cyc  = 0;

        // sync clear via swiptAlive
        run_to(206);
        chk("alive_start", 32'(adc_start), 1);
        chk("alive_grant", 32'(grant), 32'h2);
        run_to(208);
        swiptAlive = 1'b0;
        chk("alive_pre", 32'(grant), 32'h2);
        step();
        swiptAlive = 1'b1;
        chk("alive_outs", outs, 0);
        run_to(414);
        chk("alive_nostart", 32'(adc_start), 0);
        run_to(415);
        chk("alive_restart", 32'(last_start), 415);
        serve(12'h456, 2'b10);

        chk("onehot", 32'(n_oh), 0);
        chk("terr_total", 32'(n_terr), 1);
        chk("start_total", 32'(n_start), 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
